// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave single-bit writer:
//   - state_e      : FSM state encoding of the bit writer
//   - SDA_RELEASE  : value placed on SDA when the line is released (1'bz)
//   - SDA_LOW      : value placed on SDA when the line is pulled low
//   - drives_sda() : states in which the accepted bit owns the SDA line
// Related configuration macro: I2C_SCL_SYNC_EN (used by i2c_scl_sync).
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOW = 3'd1,
    DRIVE    = 3'd2,
    HIGH     = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic SDA_RELEASE = 1'bz;
  localparam logic SDA_LOW     = 1'b0;

  // The bit is presented from the SCL-low phase (DRIVE) until the slot ends.
  function automatic logic drives_sda(input state_e st);
    logic v;
    case (st)
      DRIVE:   v = 1'b1;
      HIGH:    v = 1'b1;
      DONE:    v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/i2c_scl_sync.sv
// ---------------------------------------------------------------------------
// i2c_scl_sync
// Conditions the external SCL line for the bit-writer FSM.
//   clock    in  : system clock
//   reset_n  in  : asynchronous active-low reset
//   scl      in  : raw I2C clock line from the master
//   scl_s    out : SCL value as seen by the FSM
//   scl_fall out: one-cycle flag, SCL went 1 -> 0 (scl_p=1, scl_s=0)
// Configuration macro: I2C_SCL_SYNC_EN
//   defined   : scl passes through two flops (reset to 1) before scl_s
//   undefined : scl_s is scl itself; only the edge-detect flop exists
// ---------------------------------------------------------------------------
module i2c_scl_sync
  import i2c_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic scl,
  output logic scl_s,
  output logic scl_fall
);

`ifdef I2C_SCL_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer; resets to the idle (high) level of SCL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= scl;
      r_sync2 <= r_sync1;
    end
  end

  assign scl_s = r_sync2;
`else
  assign scl_s = scl;
`endif

  logic r_scl_p;

  // Previous SCL sample for falling-edge detection; idle bus level is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_p <= 1'b1;
    end else begin
      r_scl_p <= scl_s;
    end
  end

  assign scl_fall = r_scl_p & ~scl_s;

endmodule

// File: rtl/i2c_slave_write_bit.sv
// ---------------------------------------------------------------------------
// i2c_slave_write_bit
// Places one bit on the open-drain SDA line during one SCL slot, on request
// from the slave's master FSM.
//   clock   in  : system clock, rising-edge active
//   reset_n in  : asynchronous active-low reset
//   go      in  : bit request, held high until finish is seen
//   data    in  : bit value, captured when the request is accepted
//   scl     in  : I2C clock line driven by the bus master
//   finish  out : one-cycle pulse when the bit slot has completed
//   sda     out : open-drain data; 1'b0 for bit 0, 1'bz for bit 1 / idle
// Configuration macro: I2C_SCL_SYNC_EN (two-flop SCL synchronizer, see
// i2c_scl_sync).
// ---------------------------------------------------------------------------
module i2c_slave_write_bit
  import i2c_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic data,
  input  logic scl,
  output logic finish,
  output logic sda
);

  logic   w_scl_s;
  logic   w_scl_fall;
  state_e r_state;
  state_e w_state_nxt;
  logic   r_bit_q;
  logic   w_bit_nxt;
  logic   r_finish;
  logic   r_sda_drive;

  i2c_scl_sync u_scl_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .scl      (scl),
    .scl_s    (w_scl_s),
    .scl_fall (w_scl_fall)
  );

  // Next-state and bit-capture logic; a dropped go aborts any active slot.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_q;
    case (r_state)
      IDLE: begin
        if (go) begin
          w_bit_nxt = data;
          if (!w_scl_s) begin
            w_state_nxt = DRIVE;
          end else begin
            w_state_nxt = WAIT_LOW;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!go) begin
          w_state_nxt = IDLE;
        end else if (!w_scl_s) begin
          w_state_nxt = DRIVE;
        end else begin
          w_state_nxt = WAIT_LOW;
        end
      end
      DRIVE: begin
        if (!go) begin
          w_state_nxt = IDLE;
        end else if (w_scl_s) begin
          w_state_nxt = HIGH;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      HIGH: begin
        if (!go) begin
          w_state_nxt = IDLE;
        end else if (w_scl_fall) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = HIGH;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, captured bit and output registers. Outputs are decoded from the
  // next state so they line up with the state register while staying free
  // of any combinational path from the inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bit_q     <= 1'b0;
      r_finish    <= 1'b0;
      r_sda_drive <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_q     <= w_bit_nxt;
      r_finish    <= (w_state_nxt == DONE);
      r_sda_drive <= drives_sda(w_state_nxt) & ~w_bit_nxt;
    end
  end

  assign finish = r_finish;
  // Open-drain: only ever pull low; a 1 bit is left to the bus pull-up.
  assign sda    = r_sda_drive ? SDA_LOW : SDA_RELEASE;

endmodule

// File: tb/tb_i2c_slave_write_bit.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_write_bit
// Self-checking bench for i2c_slave_write_bit. SDA is pulled up, so a
// released line reads as 1. SCL is either generated (2 cycles high, 2 low)
// or held by the directed sequences.
// ---------------------------------------------------------------------------
module tb_i2c_slave_write_bit;

`ifdef I2C_SCL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int SLOT_CYCLES = 8;

  typedef struct {
    logic d;
    logic flip;
    logic exp_sda;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  logic go;
  logic data;
  logic scl;
  logic finish;
  wire  sda_w;

  pullup (sda_w);

  i2c_slave_write_bit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .data    (data),
    .scl     (scl),
    .finish  (finish),
    .sda     (sda_w)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  logic scl_auto = 1'b0;
  int   phase = 0;
  logic last_high_sda = 1'b1;
  int   fin_cnt = 0;
  int   cyc = 0;
  logic exp_q[$];
  vec_t vecs[32];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: SCL updates just after the rising edge, outputs are
  // observed on the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (scl_auto) begin
      phase = (phase + 1) % 4;
      scl   = (phase < 2);
    end
    @(negedge clock);
    cyc++;
    if (scl) last_high_sda = sda_w;
    if (finish === 1'b1) fin_cnt++;
  endtask

  // Runs SCL until a finish pulse, then scores the SDA level of the last
  // SCL-high phase against the oldest queued expectation.
  task automatic wait_finish_and_score(input string name, input logic flip, output int fin_cyc);
    int   n;
    logic got;
    logic e;
    n   = 0;
    got = 1'b0;
    fin_cyc = -1;
    while (!got && n < 40) begin
      step();
      n++;
      if (flip && n >= 2) data = ~data;
      if (finish === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no finish expected finish within 40 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      fin_cyc = cyc;
      e = exp_q.pop_front();
      check_bit(name, last_high_sda, e);
    end
  endtask

  initial begin
    logic [31:0] pat;
    int fin_cyc;
    int prev_fin;
    int fc;

    pat = 32'h13579BDF;
    for (int i = 0; i < 32; i++) begin
      vecs[i].d       = pat[31-i];
      vecs[i].flip    = ((i % 5) == 2);
      vecs[i].exp_sda = pat[31-i];
    end

    // Reset state
    reset_n = 1'b0;
    go      = 1'b0;
    data    = 1'b0;
    scl     = 1'b1;
    repeat (3) step();
    check_bit("rst_finish", finish, 1'b0);
    check_bit("rst_sda", sda_w, 1'b1);
    #2 reset_n = 1'b1;
    repeat (2) step();

    // 32-bit word, MSB first, go held across all slots
    fin_cnt  = 0;
    prev_fin = -1;
    phase    = 0;
    scl      = 1'b1;
    scl_auto = 1'b1;
    go       = 1'b1;
    for (int i = 0; i < 32; i++) begin
      data = vecs[i].d;
      exp_q.push_back(vecs[i].exp_sda);
      wait_finish_and_score("word_bit", vecs[i].flip, fin_cyc);
      if (i > 0 && fin_cyc >= 0 && prev_fin >= 0) begin
        check_int("slot_len", fin_cyc - prev_fin, SLOT_CYCLES);
      end
      prev_fin = fin_cyc;
    end
    go = 1'b0;
    check_int("word_finish_count", fin_cnt, 32);
    repeat (12) step();
    check_int("no_finish_after_go_low", fin_cnt, 32);

    // go together with SCL low skips WAIT_LOW
    scl_auto = 1'b0;
    scl = 1'b1;
    repeat (4) step();
    scl  = 1'b0;
    go   = 1'b1;
    data = 1'b0;
    check_bit("pre_drive_sda", sda_w, 1'b1);
    repeat (LAT) step();
    check_bit("skip_wait_low_sda", sda_w, 1'b0);

    // go dropped during HIGH aborts without finish
    scl = 1'b1;
    repeat (LAT + 1) step();
    check_bit("high_hold_sda", sda_w, 1'b0);
    go = 1'b0;
    step();
    check_bit("abort_release_sda", sda_w, 1'b1);
    fc  = fin_cnt;
    scl = 1'b0;
    repeat (6) step();
    scl = 1'b1;
    repeat (4) step();
    check_int("abort_no_finish", fin_cnt - fc, 0);

    // Back in IDLE: new request with SCL low drives immediately
    scl = 1'b0;
    repeat (4) step();
    go   = 1'b1;
    data = 1'b0;
    step();
    check_bit("idle_after_abort_sda", sda_w, 1'b0);

    // Reset mid-DRIVE releases SDA asynchronously
    #2 reset_n = 1'b0;
    #1;
    check_bit("async_rst_sda", sda_w, 1'b1);
    check_bit("async_rst_finish", finish, 1'b0);
    go = 1'b0;
    fc = fin_cnt;
    step();
    check_bit("in_rst_sda", sda_w, 1'b1);
    #2 reset_n = 1'b1;
    repeat (2) step();
    check_int("rst_no_finish", fin_cnt - fc, 0);

    // A later request completes a normal bit
    scl      = 1'b1;
    repeat (4) step();
    phase    = 0;
    scl_auto = 1'b1;
    go       = 1'b1;
    data     = 1'b0;
    exp_q.push_back(1'b0);
    fc = fin_cnt;
    wait_finish_and_score("post_rst_bit", 1'b0, fin_cyc);
    go = 1'b0;
    repeat (4) step();
    check_int("post_rst_finish_count", fin_cnt - fc, 1);
    check_bit("post_rst_idle_sda", sda_w, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_write_bit.md
I2C_SLAVE_WRITE_BIT -- requirements
Module: i2c_slave_write_bit

Interface
REQ-001 SHALL have no parameters; all behaviour is fixed or selected by the Configuration macro.
REQ-002 clock  input  1  single system clock; all state is updated on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 go  input  1  request to write one bit; held high by the master FSM until finish is seen.
REQ-005 data  input  1  bit value to place on SDA; sampled when the request is accepted.
REQ-006 scl  input  1  I2C clock line, driven by the external master.
REQ-007 finish  output  1  one-cycle pulse; the bit slot has completed.
REQ-008 sda  output  1  open-drain data line: drives 1'b0 for bit 0 and releases (1'bz) for bit 1 or when idle.

Function
REQ-009 SHALL use a registered Moore FSM with states IDLE, WAIT_LOW, DRIVE, HIGH, DONE.
REQ-010 scl_s is the sampled SCL value, and scl_p is scl_s delayed by one clock cycle.
REQ-011 IDLE: sda released; finish=0; if go=1, latch data into bit_q, then go to DRIVE if scl_s=0, else go to WAIT_LOW.
REQ-012 WAIT_LOW: sda released; move to DRIVE on the first cycle with scl_s=0.
REQ-013 DRIVE: sda drives bit_q (open-drain); move to HIGH when scl_s=1.
REQ-014 HIGH: sda keeps driving bit_q; move to DONE on the SCL falling edge (scl_p=1 and scl_s=0).
REQ-015 DONE: finish=1 for exactly one cycle; sda still drives bit_q; next state is unconditionally IDLE.
REQ-016 sda and finish SHALL come from registers; no combinational path from go, data or scl to any output.
REQ-017 bit_q SHALL NOT change between acceptance and DONE; changes on data are ignored after acceptance.
REQ-018 If go falls in WAIT_LOW, DRIVE or HIGH: abort to IDLE, release sda on the next cycle, and do not assert finish.
REQ-019 If go is still high in the cycle after DONE, a new bit is accepted from IDLE (back-to-back bits).
REQ-020 sda SHALL never be driven while SCL is high unless its value was set during the preceding SCL-low phase.

Reset
REQ-021 While reset_n=0: state=IDLE, finish=0, sda released, bit_q=0, scl_p=1, and synchronizer flops (if present)=1.
REQ-022 Reset asserted mid-bit SHALL release sda immediately (asynchronously) and SHALL NOT produce finish.

Configuration
REQ-023 Macro I2C_SCL_SYNC_EN: when defined, scl passes through a two-flop synchronizer (reset to 1) before becoming scl_s, adding two cycles of latency to every SCL-dependent transition.
REQ-024 Without I2C_SCL_SYNC_EN, scl_s = scl directly; only the scl_p edge-detect register exists.

Structure
REQ-025 Shared package i2c_pkg SHALL hold the FSM state typedef/encoding and the SDA_RELEASE (1'bz) and SDA_LOW constants.
REQ-026 Sub-module i2c_scl_sync SHALL contain the optional synchronizer plus the scl_p register, and SHALL output scl_s and scl_fall.

Verification
REQ-027 32 bits of 0x13579BDF, sent MSB first, with SCL 2 cycles high / 2 cycles low and go held until finish -> 32 single-cycle finish pulses; sda during each SCL-high phase = 0,0,0,1,0,0,1,1,... (bit 1 appears as Z/pull-up).
REQ-028 go asserted while scl=0 -> skip WAIT_LOW; sda driven one cycle later (three cycles later with I2C_SCL_SYNC_EN).
REQ-029 data toggled after acceptance during DRIVE/HIGH -> sda keeps the accepted value; finish timing is unchanged.
REQ-030 go dropped during HIGH -> sda released next cycle; no finish pulse; FSM back in IDLE.
REQ-031 reset_n pulsed low during DRIVE with bit 0 -> sda=Z immediately, finish=0; a later go completes a normal bit.
REQ-032 go held high across consecutive slots -> finish pulses exactly once per SCL falling edge ending each slot.
